sram_arbiter: RTL and testbench

- Round-robin arbiter that shares one SRAM_Controller request port (read_req/write_req/address/write_data/read_data/ready) between NUM_PORTS independent requesters.
- Serialises single-word read/write transactions and routes read data and completion back to the winning requester.
- Includes a watchdog that aborts a transaction if the controller never returns ready.
- Sits between client logic and the SRAM_Controller/SRAM pair.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/sram_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM request-port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_NUM_PORTS   = 2;
    localparam int DEF_ADDR_W      = 15;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after last_grant,
// wrapping to the lowest requester when nothing above it is asking.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_o
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (IDX_W'(i) > last_grant_i);
        end
        masked        = req_i & mask;
        grant_valid_o = |req_i;
        grant_o       = '0;
        // Descending scan so the lowest set index is the one left standing.
        for (int i = N - 1; i >= 0; i--) begin
            if (|masked) begin
                if (masked[i]) grant_o = IDX_W'(i);
            end else if (req_i[i]) begin
                grant_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller request port between NUM_PORTS requesters, one
// outstanding single-word access at a time, with a watchdog abort.
//
//   state | meaning
//   IDLE  | waiting for a request while the controller reports ready
//   ISSUE | one-cycle read/write request pulse to the controller
//   BUSY  | waiting for ready to drop and return; watchdog running
//   DONE  | done/err pulse to the winner, round-robin pointer advances
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        port_req,
    input  logic [NUM_PORTS-1:0]        port_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]        port_ack,
    output logic [NUM_PORTS-1:0]        port_done,
    output logic                        port_err,
    output logic [DATA_W-1:0]           port_rdata,
    output logic                        mem_read_req,
    output logic                        mem_write_req,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_read_data,
    input  logic                        mem_ready,
    output logic                        busy
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

    state_e           state_q;
    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] win_q;
    logic             we_q;
    logic             seen_low_q;
    logic [WD_W-1:0]  wd_q;
    logic [WD_W-1:0]  wd_d;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i         (port_req),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_o       (grant_idx)
    );

    assign wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= IDX_W'(NUM_PORTS - 1);
            win_q         <= '0;
            we_q          <= 1'b0;
            seen_low_q    <= 1'b0;
            wd_q          <= '0;
            port_ack      <= '0;
            port_done     <= '0;
            port_err      <= 1'b0;
            port_rdata    <= '0;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
        end else begin
            port_ack      <= '0;
            port_done     <= '0;
            port_err      <= 1'b0;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid && mem_ready) begin
                        win_q               <= grant_idx;
                        we_q                <= port_we[grant_idx];
                        mem_addr            <= port_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                        mem_wdata           <= port_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                        port_ack[grant_idx] <= 1'b1;
                        // Request pulse is registered here so it is on the pins during ISSUE.
                        mem_read_req        <= ~port_we[grant_idx];
                        mem_write_req       <= port_we[grant_idx];
                        busy                <= 1'b1;
                        state_q             <= ISSUE;
                    end
                end
                ISSUE: begin
                    seen_low_q <= 1'b0;
                    state_q    <= BUSY;
                end
                BUSY: begin
                    wd_q <= wd_d;
                    if (!mem_ready) seen_low_q <= 1'b1;
                    if (seen_low_q && mem_ready) begin
                        if (!we_q) port_rdata <= mem_read_data;
                        port_done[win_q] <= 1'b1;
                        state_q          <= DONE;
                    end else if (wd_d == WD_LIMIT) begin
                        port_err         <= 1'b1;
                        port_done[win_q] <= 1'b1;
                        state_q          <= DONE;
                    end
                end
                DONE: begin
                    last_grant_q <= win_q;
                    wd_q         <= '0;
                    busy         <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: random requesters, a behavioural SRAM
// controller, and a round-robin reference model predicting every response.
module tb_sram_arbiter;

    localparam int NP = 3;
    localparam int AW = 15;
    localparam int DW = 16;
    localparam int TO = 255;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   port_req, port_we;
    logic [NP*AW-1:0] port_addr;
    logic [NP*DW-1:0] port_wdata;
    logic [NP-1:0]   port_ack, port_done;
    logic            port_err;
    logic [DW-1:0]   port_rdata;
    logic            mem_read_req, mem_write_req;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_read_data;
    logic            mem_ready;
    logic            busy;

    always #5 clk = ~clk;

    sram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_wdata(port_wdata),
        .port_ack(port_ack), .port_done(port_done), .port_err(port_err), .port_rdata(port_rdata),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_read_data(mem_read_data), .mem_ready(mem_ready), .busy(busy)
    );

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } txn_t;
    typedef struct { int port; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;
                     logic err; logic [DW-1:0] rdata; } exp_t;

    int checks = 0, errors = 0, cyc = 0;
    txn_t pq[NP][$];
    exp_t ack_q[$], mem_q[$], done_q[$];
    int grant_log[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ctl_mem [int];
    logic [DW-1:0] model_rdata = '0;
    int  model_last = NP - 1;
    bit  model_idle = 1'b1, holdoff = 1'b0, hang_mode = 1'b0, ctl_block = 1'b0;
    int  ctl_st = 0, ctl_cnt = 0;
    logic ctl_we;
    logic [AW-1:0] ctl_addr;
    logic [DW-1:0] ctl_wdata;
    int  req_cyc = 0, wd_cycles = 0, rd_pulses = 0;
    logic last_err = 1'b0, last_kind_wr = 1'b0;
    logic [DW-1:0] last_rdata = '0, last_mwdata = '0;
    logic [AW-1:0] last_maddr = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requesters: hold req until ack, then present the next queued transaction.
    initial begin
        txn_t t;
        port_req = '0; port_we = '0; port_addr = '0; port_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int p = 0; p < NP; p++) begin
                    if (port_ack[p]) port_req[p] = 1'b0;
                    if (!port_req[p] && pq[p].size() > 0) begin
                        t = pq[p].pop_front();
                        port_we[p] = t.we;
                        port_addr[p*AW +: AW] = t.addr;
                        port_wdata[p*DW +: DW] = t.wdata;
                        port_req[p] = 1'b1;
                    end
                end
            end
        end
    end

    // SRAM controller model: accept, drop ready, complete after 2..6 cycles (or never when hanging).
    initial begin
        mem_ready = 1'b1; mem_read_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                case (ctl_st)
                    0: if (mem_read_req || mem_write_req) begin
                        ctl_we = mem_write_req; ctl_addr = mem_addr; ctl_wdata = mem_wdata;
                        mem_ready = 1'b0;
                        mem_read_data = DW'($urandom);
                        ctl_cnt = $urandom_range(2, 6);
                        ctl_st = hang_mode ? 2 : 1;
                    end else begin
                        mem_ready = !ctl_block;
                    end
                    1: begin
                        ctl_cnt--;
                        if (ctl_cnt == 0) begin
                            if (ctl_we) begin
                                ctl_mem[int'(ctl_addr)] = ctl_wdata;
                                mem_read_data = DW'($urandom);
                            end else begin
                                mem_read_data = ctl_mem.exists(int'(ctl_addr)) ? ctl_mem[int'(ctl_addr)] : '0;
                            end
                            mem_ready = 1'b1;
                            ctl_st = 0;
                        end
                    end
                    default: if (port_done != 0) begin
                        mem_ready = 1'b1;
                        ctl_st = 0;
                    end
                endcase
            end
        end
    end

    // Reference model: at each arbitration opportunity pick the round-robin winner and predict its outcome.
    initial begin
        exp_t e;
        int w;
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (model_idle && port_req != 0 && mem_ready === 1'b1) begin
                    w = -1;
                    for (int k = 1; k <= NP; k++)
                        if (w < 0 && port_req[(model_last + k) % NP]) w = (model_last + k) % NP;
                    e.port = w; e.we = port_we[w];
                    e.addr = port_addr[w*AW +: AW]; e.wdata = port_wdata[w*DW +: DW];
                    e.err = hang_mode;
                    if (hang_mode) e.rdata = model_rdata;
                    else if (e.we) begin
                        ref_mem[int'(e.addr)] = e.wdata;
                        e.rdata = model_rdata;
                    end else begin
                        e.rdata = ref_mem.exists(int'(e.addr)) ? ref_mem[int'(e.addr)] : '0;
                        model_rdata = e.rdata;
                    end
                    ack_q.push_back(e); mem_q.push_back(e); done_q.push_back(e);
                    model_last = w;
                    model_idle = 1'b0;
                end
                if (holdoff) begin
                    holdoff = 1'b0;
                    model_idle = 1'b1;
                end
            end
        end
    end

    // Monitor: compares every ack, controller request and done against the scoreboard queues.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (port_ack != 0 || ack_q.size() != 0) begin
                    if (ack_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ack_unexpected: got %b expected none", port_ack);
                    end else begin
                        e = ack_q.pop_front();
                        check("ack_vector", 64'(port_ack), 64'(1 << e.port));
                    end
                    for (int p = 0; p < NP; p++) if (port_ack[p]) grant_log.push_back(p);
                end
                if (mem_read_req || mem_write_req) begin
                    if (mem_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mem_req_unexpected: got rd=%b wr=%b expected none", mem_read_req, mem_write_req);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_write_req", 64'(mem_write_req), 64'(e.we));
                        check("mem_read_req", 64'(mem_read_req), 64'(!e.we));
                        check("mem_addr", 64'(mem_addr), 64'(e.addr));
                        if (e.we) check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                    end
                    req_cyc = cyc;
                    if (mem_read_req) rd_pulses++;
                    last_kind_wr = mem_write_req; last_maddr = mem_addr; last_mwdata = mem_wdata;
                end
                if (port_done != 0) begin
                    if (done_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected: got %b expected none", port_done);
                    end else begin
                        e = done_q.pop_front();
                        check("done_vector", 64'(port_done), 64'(1 << e.port));
                        check("port_err", 64'(port_err), 64'(e.err));
                        check("port_rdata", 64'(port_rdata), 64'(e.rdata));
                        if (e.err) begin
                            wd_cycles = cyc - req_cyc;
                            check("watchdog_cycles", 64'(wd_cycles), 64'(TO + 1));
                        end
                    end
                    last_err = port_err; last_rdata = port_rdata;
                    holdoff = 1'b1;
                end
            end
        end
    end

    task automatic enq(int p, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        pq[p].push_back(t);
    endtask

    function automatic bit all_idle();
        bit r = (port_req == 0) && ack_q.size() == 0 && mem_q.size() == 0 && done_q.size() == 0
                && model_idle && !holdoff && ctl_st == 0 && busy == 1'b0;
        for (int p = 0; p < NP; p++) if (pq[p].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(string tag);
        int n = 0;
        while (!all_idle() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #2;
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: still active after %0d cycles, expected idle", tag, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_ack", 64'(port_ack), 0);
        check("rst_done", 64'(port_done), 0);
        check("rst_mem_read_req", 64'(mem_read_req), 0);
        check("rst_mem_write_req", 64'(mem_write_req), 0);
        check("rst_port_err", 64'(port_err), 0);
        check("rst_port_rdata", 64'(port_rdata), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);
        for (int p = 0; p < NP; p++) pq[p].delete();
        ack_q.delete(); mem_q.delete(); done_q.delete();
        port_req = '0;
        model_idle = 1'b1; holdoff = 1'b0; model_last = NP - 1; model_rdata = '0;
        hang_mode = 1'b0; ctl_block = 1'b0; ctl_st = 0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int g0, n, r0;
        int order [4];
        order = '{0, 1, 0, 1};
        do_reset();

        enq(0, 1'b1, 15'h0010, 16'hBEEF);
        wait_idle("write");
        check("wr_kind", 64'(last_kind_wr), 1);
        check("wr_addr", 64'(last_maddr), 64'h10);
        check("wr_wdata", 64'(last_mwdata), 64'hBEEF);
        check("wr_err", 64'(last_err), 0);

        r0 = rd_pulses;
        enq(1, 1'b0, 15'h0010, 16'h0000);
        wait_idle("readback");
        check("rd_pulses", 64'(rd_pulses - r0), 1);
        check("rd_data", 64'(last_rdata), 64'hBEEF);

        do_reset();
        g0 = grant_log.size();
        enq(0, 1'b1, 15'h0020, 16'h1111);
        enq(1, 1'b1, 15'h0021, 16'h2222);
        enq(0, 1'b0, 15'h0021, 16'h0000);
        enq(1, 1'b0, 15'h0020, 16'h0000);
        wait_idle("contention");
        check("contention_count", 64'(grant_log.size() - g0), 4);
        if (grant_log.size() - g0 == 4)
            for (int i = 0; i < 4; i++) check("contention_order", 64'(grant_log[g0 + i]), 64'(order[i]));

        ctl_block = 1'b1; mem_ready = 1'b0;
        g0 = grant_log.size();
        enq(0, 1'b0, 15'h0020, 16'h0000);
        repeat (10) @(negedge clk);
        #2;
        check("no_ack_not_ready", 64'(grant_log.size() - g0), 0);
        check("busy_not_ready", 64'(busy), 0);
        ctl_block = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("ack_after_ready", 64'(grant_log.size() - g0), 1);
        wait_idle("not_ready");

        hang_mode = 1'b1;
        enq(1, 1'b0, 15'h0020, 16'h0000);
        wait_idle("watchdog");
        hang_mode = 1'b0;
        check("wd_err", 64'(last_err), 1);
        check("wd_span", 64'(wd_cycles), 64'(TO + 1));
        enq(0, 1'b0, 15'h0021, 16'h0000);
        wait_idle("after_watchdog");
        check("post_wd_err", 64'(last_err), 0);
        check("post_wd_rdata", 64'(last_rdata), 64'h2222);

        repeat (4) begin
            for (int k = 0; k < 12; k++) begin
                enq($urandom_range(0, NP - 1), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 7)), DW'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                #2;
            end
            wait_idle("random");
        end

        hang_mode = 1'b1;
        enq(2, 1'b1, 15'h0005, 16'h5555);
        n = 0;
        while (!(busy === 1'b1 && mem_q.size() == 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2;
        check("busy_before_rst", 64'(busy), 1);
        do_reset();
        g0 = grant_log.size();
        enq(1, 1'b0, 15'h0021, 16'h0000);
        enq(0, 1'b0, 15'h0020, 16'h0000);
        wait_idle("after_reset");
        check("post_rst_count", 64'(grant_log.size() - g0), 2);
        if (grant_log.size() - g0 == 2) begin
            check("post_rst_first", 64'(grant_log[g0]), 0);
            check("post_rst_second", 64'(grant_log[g0 + 1]), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "global timeout");
    end

endmodule
